// File: rtl/uncached_axi_bridge.sv
// Bridges the core's SRAM-like uncached data request port onto single-beat AXI4
// reads and writes, one transaction outstanding at a time, in program order.
module uncached_axi_bridge #(
  parameter logic [3:0] AXI_ID = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic        resp_err,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata_axi,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata_axi,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [1:0]  size_q;
  logic        aw_done, w_done, resp_err_q;
  logic        aw_hs, w_hs, wr_both_done;

  // IDs, the ignored response bits and rlast carry nothing this bridge needs.
  logic unused_inputs;
  assign unused_inputs = ^{rid, bid, rlast, rresp[0], bresp[0]};

  function automatic logic [3:0] strb_of(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'd0:    strb_of = 4'b0001 << off;
      2'd1:    strb_of = off[1] ? 4'b1100 : 4'b0011;
      default: strb_of = 4'b1111;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      rdata_q    <= '0;
      resp_err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        RD_DATA: if (rvalid) begin
          rdata_q    <= rdata_axi;
          resp_err_q <= rresp[1];
        end
        WR_REQ: begin
          if (wr_both_done) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end else begin
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
          end
        end
        WR_RESP: if (bvalid) resp_err_q <= bresp[1];
        DONE:    resp_err_q <= 1'b0;
        default: ;
      endcase
    end
  end

  // Request payload is plain data: captured on accept, never reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && req) begin
      addr_q  <= addr;
      size_q  <= size;
      wdata_q <= wdata;
    end
  end

  always_comb begin
    state_nxt    = state;
    arvalid      = 1'b0;
    rready       = 1'b0;
    awvalid      = 1'b0;
    wvalid       = 1'b0;
    bready       = 1'b0;
    addr_ok      = 1'b0;
    data_ok      = 1'b0;
    aw_hs        = 1'b0;
    w_hs         = 1'b0;
    wr_both_done = 1'b0;
    case (state)
      IDLE: begin
        addr_ok = 1'b1;
        if (req) state_nxt = wr ? WR_REQ : RD_ADDR;
      end
      RD_ADDR: begin
        arvalid = 1'b1;
        if (arready) state_nxt = RD_DATA;
      end
      RD_DATA: begin
        rready = 1'b1;
        if (rvalid) state_nxt = DONE;
      end
      WR_REQ: begin
        awvalid      = !aw_done;
        wvalid       = !w_done;
        aw_hs        = awvalid && awready;
        w_hs         = wvalid && wready;
        wr_both_done = (aw_done || aw_hs) && (w_done || w_hs);
        if (wr_both_done) state_nxt = WR_RESP;
      end
      WR_RESP: begin
        bready = 1'b1;
        if (bvalid) state_nxt = DONE;
      end
      DONE: begin
        data_ok   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rdata    = rdata_q;
  assign resp_err = resp_err_q;

  assign arid    = AXI_ID;
  assign araddr  = addr_q;
  assign arlen   = 4'd0;
  assign arsize  = (size_q == 2'd3) ? 3'b010 : {1'b0, size_q};
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;

  assign awid    = AXI_ID;
  assign awaddr  = addr_q;
  assign awlen   = 4'd0;
  assign awsize  = arsize;
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;

  assign wid       = AXI_ID;
  assign wdata_axi = wdata_q;
  assign wstrb     = strb_of(size_q, addr_q[1:0]);
  assign wlast     = 1'b1;

endmodule

// File: tb/tb_uncached_axi_bridge.sv
// Directed bench for uncached_axi_bridge: the main process plays core and AXI slave,
// a negedge monitor checks each data_ok against a queue of expected completions.
module tb_uncached_axi_bridge;

  logic        clk, rst, req, wr;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        addr_ok, data_ok, resp_err;
  logic [31:0] rdata;
  logic [3:0]  arid, arlen, arcache, awid, awlen, awcache, wid, wstrb, rid, bid;
  logic [31:0] araddr, awaddr, rdata_axi, wdata_axi;
  logic [2:0]  arsize, arprot, awsize, awprot;
  logic [1:0]  arburst, arlock, awburst, awlock, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  uncached_axi_bridge #(.AXI_ID(4'd1)) dut (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .size(size), .addr(addr), .wdata(wdata),
    .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata), .resp_err(resp_err),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata_axi(rdata_axi), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata_axi(wdata_axi), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  typedef struct {
    logic        is_rd;
    logic [31:0] data;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   last_dok_cyc = -1;
  logic prev_dok = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every data_ok must match the oldest expected completion.
  always @(negedge clk) begin
    if (data_ok) begin
      exp_t e;
      chk("addr_ok_low_in_done", {31'd0, addr_ok}, 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_data_ok", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
        if (e.is_rd) chk("rdata", rdata, e.data);
        if (e.lat > 0) chk("latency", cyc - e.acc, e.lat);
      end
      last_dok_cyc = cyc;
    end else if (prev_dok) begin
      chk("resp_err_cleared", {31'd0, resp_err}, 32'd0);
    end
    prev_dok = data_ok;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_rsp(input logic is_rd, input logic [31:0] d, input logic e, input int lat);
    exp_t x;
    x.is_rd = is_rd; x.data = d; x.err = e; x.lat = lat; x.acc = acc_cyc;
    sb.push_back(x);
  endtask

  task automatic issue(input logic w, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] d, input logic keep);
    int n;
    n = 0;
    req = 1'b1; wr = w; size = sz; addr = a; wdata = d;
    while (!addr_ok && n < 20) begin tick(); n++; end
    chk("accept_wait", {31'd0, addr_ok}, 32'd1);
    acc_cyc = cyc;
    tick();
    req = keep;
  endtask

  task automatic slave_read(input int ar_dly, input int r_dly, input logic [31:0] a,
                            input logic [2:0] exp_sz, input logic [31:0] d, input logic [1:0] rsp);
    int  c;
    logic hs;
    chk("araddr", araddr, a);
    chk("arsize", {29'd0, arsize}, {29'd0, exp_sz});
    chk("arlen_arburst_arid", {arlen, 2'b00, arburst, arid}, {4'd0, 2'b00, 2'b01, 4'd1});
    c = 0; hs = 1'b0;
    while (!hs && c < 30) begin
      arready = (c >= ar_dly);
      chk("arvalid_held", {31'd0, arvalid}, 32'd1);
      chk("araddr_stable", araddr, a);
      hs = arvalid && arready;
      tick();
      c++;
    end
    arready = 1'b0;
    c = 0; hs = 1'b0;
    while (!hs && c < 30) begin
      rvalid = (c >= r_dly);
      rdata_axi = d;
      rresp = rsp;
      chk("rready", {31'd0, rready}, 32'd1);
      hs = rvalid && rready;
      tick();
      c++;
    end
    rvalid = 1'b0;
    rresp = 2'b00;
  endtask

  task automatic slave_write(input int aw_dly, input int w_dly, input int b_dly, input logic [1:0] rsp,
                             input logic [31:0] a, input logic [2:0] exp_sz,
                             input logic [3:0] exp_strb, input logic [31:0] d);
    int   c;
    logic aw_seen, w_seen, aw_hs, w_hs, hs;
    chk("awaddr", awaddr, a);
    chk("awsize", {29'd0, awsize}, {29'd0, exp_sz});
    chk("wstrb", {28'd0, wstrb}, {28'd0, exp_strb});
    chk("wdata_axi", wdata_axi, d);
    chk("awlen_awburst_wlast_ids", {awlen, awburst, wlast, awid, wid},
        {4'd0, 2'b01, 1'b1, 4'd1, 4'd1});
    c = 0; aw_seen = 1'b0; w_seen = 1'b0;
    while (!(aw_seen && w_seen) && c < 30) begin
      awready = (c >= aw_dly) && !aw_seen;
      wready  = (c >= w_dly) && !w_seen;
      chk("awvalid", {31'd0, awvalid}, {31'd0, !aw_seen});
      chk("wvalid", {31'd0, wvalid}, {31'd0, !w_seen});
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      tick();
      aw_seen = aw_seen | aw_hs;
      w_seen  = w_seen | w_hs;
      c++;
    end
    awready = 1'b0;
    wready  = 1'b0;
    chk("wr_handshakes_done", {30'd0, aw_seen, w_seen}, 32'd3);
    c = 0; hs = 1'b0;
    while (!hs && c < 30) begin
      bvalid = (c >= b_dly);
      bresp  = rsp;
      chk("bready", {31'd0, bready}, 32'd1);
      chk("no_valid_in_wr_resp", {30'd0, awvalid, wvalid}, 32'd0);
      hs = bvalid && bready;
      tick();
      c++;
    end
    bvalid = 1'b0;
    bresp  = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req = 1'b0; wr = 1'b0; size = 2'd0; addr = '0; wdata = '0;
    arready = 1'b0; rid = 4'd1; rdata_axi = '0; rresp = 2'b00; rlast = 1'b1; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bid = 4'd1; bresp = 2'b00; bvalid = 1'b0;
    tick(); tick();
    chk("rst_valids", {26'd0, arvalid, rready, awvalid, wvalid, bready, data_ok}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst_addr_ok", {31'd0, addr_ok}, 32'd1);
    rst = 1'b0;
    tick();

    // Word load, arready after two cycles.
    issue(1'b0, 2'd2, 32'h1FD0_F000, 32'h0, 1'b0);
    expect_rsp(1'b1, 32'hDEAD_BEEF, 1'b0, 0);
    slave_read(2, 0, 32'h1FD0_F000, 3'b010, 32'hDEAD_BEEF, 2'b00);
    tick(); tick();

    // Byte store to lane 3.
    issue(1'b1, 2'd0, 32'hBFAF_F003, 32'h5A5A_5A5A, 1'b0);
    expect_rsp(1'b0, 32'h0, 1'b0, 0);
    slave_write(1, 1, 2, 2'b00, 32'hBFAF_F003, 3'b000, 4'b1000, 32'h5A5A_5A5A);
    tick(); tick();
    chk("rdata_held_after_store", rdata, 32'hDEAD_BEEF);

    // Half store, W handshake three cycles before AW.
    issue(1'b1, 2'd1, 32'hBFAF_0002, 32'h1234_1234, 1'b0);
    expect_rsp(1'b0, 32'h0, 1'b0, 0);
    slave_write(3, 0, 0, 2'b00, 32'hBFAF_0002, 3'b001, 4'b1100, 32'h1234_1234);
    tick();

    // Byte store to lane 1, AW first.
    issue(1'b1, 2'd0, 32'h0000_1001, 32'h7777_7777, 1'b0);
    expect_rsp(1'b0, 32'h0, 1'b0, 0);
    slave_write(0, 2, 0, 2'b00, 32'h0000_1001, 3'b000, 4'b0010, 32'h7777_7777);
    tick();

    // Back-to-back load then store with req held high, zero-wait slave.
    issue(1'b0, 2'd2, 32'h1FD0_0004, 32'h0, 1'b1);
    expect_rsp(1'b1, 32'h0BAD_F00D, 1'b0, 3);
    slave_read(0, 0, 32'h1FD0_0004, 3'b010, 32'h0BAD_F00D, 2'b00);
    issue(1'b1, 2'd2, 32'h1FD0_0008, 32'hCAFE_F00D, 1'b0);
    chk("b2b_accept_after_data_ok", acc_cyc, last_dok_cyc + 1);
    expect_rsp(1'b0, 32'h0, 1'b0, 3);
    slave_write(0, 0, 0, 2'b00, 32'h1FD0_0008, 3'b010, 4'b1111, 32'hCAFE_F00D);
    tick(); tick();

    // Error responses: SLVERR on a load, DECERR on a size=3 store.
    issue(1'b0, 2'd2, 32'h1FD0_0010, 32'h0, 1'b0);
    expect_rsp(1'b1, 32'h1122_3344, 1'b1, 0);
    slave_read(1, 1, 32'h1FD0_0010, 3'b010, 32'h1122_3344, 2'b10);
    tick(); tick();
    issue(1'b1, 2'd3, 32'h1FD0_0014, 32'hA5A5_0F0F, 1'b0);
    expect_rsp(1'b0, 32'h0, 1'b1, 0);
    slave_write(0, 0, 1, 2'b11, 32'h1FD0_0014, 3'b010, 4'b1111, 32'hA5A5_0F0F);
    tick(); tick();

    // Reset while waiting for read data: no completion may follow.
    issue(1'b0, 2'd2, 32'h1FD0_0020, 32'h0, 1'b0);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    chk("abort_in_rd_data", {30'd0, rready, arvalid}, 32'd2);
    rst = 1'b1;
    tick();
    chk("abort_valids_dropped", {30'd0, arvalid, rready}, 32'd0);
    chk("abort_addr_ok", {31'd0, addr_ok}, 32'd1);
    rst = 1'b0;
    repeat (6) tick();

    // A normal load still works after the abort.
    issue(1'b0, 2'd0, 32'h1FD0_0031, 32'h0, 1'b0);
    expect_rsp(1'b1, 32'h0000_00AB, 1'b0, 3);
    slave_read(0, 0, 32'h1FD0_0031, 3'b000, 32'h0000_00AB, 2'b00);
    repeat (4) tick();

    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uncached_axi_bridge.md
Name: uncached_axi_bridge

Overview:
- Converts the core's SRAM-like data request interface (req/wr/size/addr/wdata, addr_ok/data_ok handshake) into single-beat AXI4 read or write transactions.
- Sits between the data-side uncached path of the split-cache adapter and the AXI port, downstream of the core.
- Used for MMIO and other uncached loads/stores.
- At most one transaction outstanding; strict program order.

Parameters:
- AXI_ID, 4'd1, value driven on arid/awid/wid; returned rid/bid are ignored.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req  in  1  request valid
- wr  in  1  1=store, 0=load
- size  in  2  0=byte, 1=half, 2=word (3 treated as word)
- addr  in  32  physical byte address
- wdata  in  32  store data, already lane-replicated by the core
- addr_ok  out  1  request accepted this cycle when req&&addr_ok
- data_ok  out  1  one-cycle completion pulse
- rdata  out  32  load data, valid while data_ok=1
- resp_err  out  1  high with data_ok when rresp/bresp[1]=1 (SLVERR/DECERR)
- AXI master: arid[3:0] araddr[31:0] arlen[3:0] arsize[2:0] arburst[1:0] arlock[1:0] arcache[3:0] arprot[2:0] arvalid out, arready in; rid[3:0] rdata_axi[31:0] rresp[1:0] rlast rvalid in, rready out; awid awaddr awlen awsize awburst awlock awcache awprot awvalid out, awready in; wid[3:0] wdata_axi[31:0] wstrb[3:0] wlast wvalid out, wready in; bid[3:0] bresp[1:0] bvalid in, bready out.

Behaviour:
- Clock and reset: one clock clk; rst is synchronous, active-high.
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- Reset values: state=IDLE; all valid/ready outputs 0; data_ok=0; resp_err=0; rdata=0; aw_done=w_done=0.
- addr_ok = (state==IDLE), combinational.
- Accept (req&&addr_ok): latch addr, wr, size, wdata. Next state is RD_ADDR if wr=0, WR_REQ if wr=1.
- Constant AXI fields: arlen=awlen=0, arburst=awburst=2'b01, arlock=awlock=0, arcache=awcache=0, arprot=awprot=0, wlast=1.
- arsize=awsize={1'b0,size'}, where size'=2 if size==3. araddr=awaddr=latched addr, unmodified.
- wstrb:
  - size0: 4'b0001<<addr[1:0]
  - size1: addr[1]?4'b1100:4'b0011
  - word: 4'b1111
- RD_ADDR: arvalid=1, held until arready. arready -> RD_DATA next cycle.
- RD_DATA: rready=1. On rvalid (rlast assumed 1): register rdata_axi into rdata, register resp_err=rresp[1], go DONE.
- WR_REQ: awvalid=!aw_done, wvalid=!w_done, both raised in the same first cycle.
  - aw_done is set on awready&&awvalid; w_done on wready&&wvalid. Either order is legal, including both in the same cycle.
  - When both handshakes are complete (set flags or this-cycle handshakes): clear both flags, go WR_RESP.
- WR_RESP: bready=1. On bvalid: resp_err=bresp[1], go DONE.
- DONE: data_ok=1 for exactly one cycle, with rdata/resp_err valid. Next state IDLE. rdata holds its value afterwards; resp_err clears.
- addr_ok is low in DONE, so a new request can be accepted no earlier than the cycle after data_ok.
- Minimum latency, accept cycle to data_ok, with zero-wait slave (arready/rvalid immediately):
  - read: 3 cycles (accept→RD_ADDR→RD_DATA→DONE)
  - write: 3 cycles (accept→WR_REQ→WR_RESP→DONE)
- Valid stability: a valid, once raised, is held with its payload unchanged until its handshake. No combinational path from AXI inputs to any AXI valid output.
- req is ignored outside IDLE. The upstream must hold req/addr stable only until addr_ok.
- Reset mid-transaction: returns to IDLE and drops all valids the next edge. The AXI slave is reset concurrently. No data_ok is issued for the aborted request.
- Error response: data still completes normally (rdata captured), with resp_err=1.

Test Plan:
- Word load addr=0x1FD0_F000, slave: arready after 2 cycles, rdata_axi=0xDEAD_BEEF, rresp=0 -> araddr=0x1FD0F000, arsize=3'b010, arlen=0. data_ok one cycle, rdata=0xDEADBEEF, resp_err=0.
- Byte store size=0, addr=0xBFAF_F003, wdata=0x5A5A_5A5A -> awsize=0, wstrb=4'b1000, wdata_axi=0x5A5A5A5A, wlast=1. data_ok after bvalid.
- Half store addr=...02: slave asserts wready 3 cycles before awready -> wvalid drops after its handshake, awvalid held; wstrb=4'b1100; one WR_RESP, one data_ok.
- Back-to-back: load then store with req held high -> second addr_ok only in the cycle after the first data_ok. Zero-wait slave gives 3-cycle latency for each.
- rresp=2'b10 on a word load -> data_ok=1 with resp_err=1 for that cycle only. bresp=2'b11 on a store -> same behaviour.
- rst asserted while in RD_DATA -> next cycle: arvalid=rready=0, addr_ok=1, and no data_ok ever pulses for that load.
